// File: rtl/usb_pkg.sv
// Shared definitions for the USB transmit scheduler: packet-type codes,
// FSM states, source indices and the SYNC pattern.
package usb_pkg;

    localparam int NUM_SRC = 3;

    localparam int SRC_TOK  = 0;
    localparam int SRC_DATA = 1;
    localparam int SRC_HS   = 2;

    localparam logic [1:0] TYPE_NON  = 2'b00;
    localparam logic [1:0] TYPE_TOK  = 2'b01;
    localparam logic [1:0] TYPE_DATA = 2'b10;
    localparam logic [1:0] TYPE_HS   = 2'b11;

    localparam int SYNC_LEN_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_XFER,
        ST_EOP,
        ST_J,
        ST_GAP
    } state_t;

    // SYNC is len-1 zeros followed by a single one, sent LSB-first
    function automatic logic [15:0] sync_pattern(input int len);
        return 16'(1) << (len - 1);
    endfunction

endpackage

// File: rtl/usb_tx_sched_if.sv
// Packet-builder side and NRZI side of the transmit scheduler.
interface usb_tx_sched_if;

    logic [usb_pkg::NUM_SRC-1:0] req;
    logic [usb_pkg::NUM_SRC-1:0] bit_in;
    logic [usb_pkg::NUM_SRC-1:0] bit_valid;
    logic [usb_pkg::NUM_SRC-1:0] bit_last;
    logic [usb_pkg::NUM_SRC-1:0] bit_take;
    logic [usb_pkg::NUM_SRC-1:0] gnt;
    logic                        bstr_out;
    logic [1:0]                  bstr_out_ready;
    logic                        se0;
    logic                        busy;
    logic                        abort;

    modport master (
        output req, bit_in, bit_valid, bit_last,
        input  bit_take, gnt, bstr_out, bstr_out_ready, se0, busy, abort
    );

    modport slave (
        input  req, bit_in, bit_valid, bit_last,
        output bit_take, gnt, bstr_out, bstr_out_ready, se0, busy, abort
    );

endinterface

// File: rtl/usb_prio_arb.sv
// Fixed-priority one-hot picker: handshake > token > data.
module usb_prio_arb import usb_pkg::*; (
    input  logic [NUM_SRC-1:0] req,
    output logic [NUM_SRC-1:0] pick
);

    always_comb begin
        pick = '0;
        if (req[SRC_HS])
            pick[SRC_HS] = 1'b1;
        else if (req[SRC_TOK])
            pick[SRC_TOK] = 1'b1;
        else if (req[SRC_DATA])
            pick[SRC_DATA] = 1'b1;
    end

endmodule

// File: rtl/usb_tx_sched.sv
// Shares the serial encode path between token, data and handshake sources:
// SYNC, payload, EOP, J, then an inter-packet gap before the next grant.
module usb_tx_sched import usb_pkg::*; #(
    parameter int IPG_CYCLES = 2,
    parameter int SYNC_LEN   = SYNC_LEN_DEF
) (
    input  logic          clk,
    input  logic          rst_b,
    usb_tx_sched_if.slave bus
);

    localparam logic [15:0] SYNC_PAT  = sync_pattern(SYNC_LEN);
    localparam logic [3:0]  SYNC_LAST = 4'(SYNC_LEN - 1);
    localparam logic [3:0]  GAP_LAST  = 4'(IPG_CYCLES - 1);

    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] gnt, gnt_nxt;
    logic [NUM_SRC-1:0] pick;
    logic [NUM_SRC-1:0] take;
    logic [3:0]         sync_cnt, sync_cnt_nxt;
    logic [3:0]         gap_cnt, gap_cnt_nxt;
    logic               eop_cnt, eop_cnt_nxt;
    logic               bstr, bstr_nxt;
    logic [1:0]         rdy, rdy_nxt;
    logic               se0, se0_nxt;
    logic               abort, abort_nxt;
    logic [1:0]         gtype;
    logic               g_valid, g_last, g_bit;

    usb_prio_arb u_arb (
        .req  (bus.req),
        .pick (pick)
    );

    // Lane of the granted source; the one-hot grant doubles as the select
    assign g_valid = |(gnt & bus.bit_valid);
    assign g_last  = |(gnt & bus.bit_last);
    assign g_bit   = |(gnt & bus.bit_in);

    always_comb begin
        gtype = TYPE_NON;
        if (gnt[SRC_TOK])  gtype = TYPE_TOK;
        if (gnt[SRC_DATA]) gtype = TYPE_DATA;
        if (gnt[SRC_HS])   gtype = TYPE_HS;
    end

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        sync_cnt_nxt = sync_cnt;
        gap_cnt_nxt  = gap_cnt;
        eop_cnt_nxt  = eop_cnt;
        bstr_nxt     = bstr;
        rdy_nxt      = rdy;
        se0_nxt      = se0;
        abort_nxt    = 1'b0;
        take         = '0;

        unique case (state)
            ST_IDLE: begin
                if (|bus.req) begin
                    gnt_nxt      = pick;
                    sync_cnt_nxt = '0;
                    state_nxt    = ST_SYNC;
                end
            end

            ST_SYNC: begin
                bstr_nxt = SYNC_PAT[sync_cnt];
                rdy_nxt  = gtype;
                if (sync_cnt == SYNC_LAST)
                    state_nxt = ST_XFER;
                else
                    sync_cnt_nxt = sync_cnt + 4'd1;
            end

            ST_XFER: begin
                take = gnt & bus.bit_valid;
                if (g_valid) begin
                    bstr_nxt = g_bit;
                    rdy_nxt  = gtype;
                    if (g_last) begin
                        eop_cnt_nxt = 1'b0;
                        state_nxt   = ST_EOP;
                    end
                end else begin
                    // Underrun: type code drops and the packet is closed with EOP
                    rdy_nxt     = TYPE_NON;
                    abort_nxt   = 1'b1;
                    eop_cnt_nxt = 1'b0;
                    state_nxt   = ST_EOP;
                end
            end

            ST_EOP: begin
                se0_nxt  = 1'b1;
                bstr_nxt = 1'b0;
                rdy_nxt  = TYPE_NON;
                if (eop_cnt) begin
                    eop_cnt_nxt = 1'b0;
                    state_nxt   = ST_J;
                end else begin
                    eop_cnt_nxt = 1'b1;
                end
            end

            ST_J: begin
                se0_nxt     = 1'b0;
                bstr_nxt    = 1'b1;
                rdy_nxt     = TYPE_NON;
                gnt_nxt     = '0;
                gap_cnt_nxt = '0;
                state_nxt   = (IPG_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end

            ST_GAP: begin
                if (gap_cnt == GAP_LAST)
                    state_nxt = ST_IDLE;
                else
                    gap_cnt_nxt = gap_cnt + 4'd1;
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            sync_cnt <= '0;
            gap_cnt  <= '0;
            eop_cnt  <= 1'b0;
            bstr     <= 1'b1;
            rdy      <= TYPE_NON;
            se0      <= 1'b0;
            abort    <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            sync_cnt <= sync_cnt_nxt;
            gap_cnt  <= gap_cnt_nxt;
            eop_cnt  <= eop_cnt_nxt;
            bstr     <= bstr_nxt;
            rdy      <= rdy_nxt;
            se0      <= se0_nxt;
            abort    <= abort_nxt;
        end
    end

    assign bus.bit_take       = take;
    assign bus.gnt            = gnt;
    assign bus.bstr_out       = bstr;
    assign bus.bstr_out_ready = rdy;
    assign bus.se0            = se0;
    assign bus.abort          = abort;
    assign bus.busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_usb_tx_sched.sv
// Scenario-table and random bench for usb_tx_sched against a packet-timeline model.
module tb_usb_tx_sched;
    import usb_pkg::*;

    localparam int IPG = 2;
    localparam int SL  = 8;
    localparam int NONE = 99;

    typedef struct {
        int         start[3];
        int         len[3];
        int         under[3];
        logic [2:0] first_gnt;
    } scen_t;

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    usb_tx_sched_if bus ();
    usb_tx_sched_if bus0 ();

    usb_tx_sched #(.IPG_CYCLES(IPG), .SYNC_LEN(SL)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    usb_tx_sched #(.IPG_CYCLES(0), .SYNC_LEN(SL)) dut0 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus0)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic scen_t mk(input int s0, input int s1, input int s2,
                                 input int l0, input int l1, input int l2,
                                 input int u0, input int u1, input int u2,
                                 input logic [2:0] fg);
        scen_t s;
        s.start[0] = s0; s.start[1] = s1; s.start[2] = s2;
        s.len[0]   = l0; s.len[1]   = l1; s.len[2]   = l2;
        s.under[0] = u0; s.under[1] = u1; s.under[2] = u2;
        s.first_gnt = fg;
        return s;
    endfunction

    // Handshake first, then token, then data
    function automatic int pick(input logic [2:0] p);
        int order[3] = '{2, 0, 1};
        for (int k = 0; k < 3; k++)
            if (p[order[k]]) return order[k];
        return -1;
    endfunction

    task automatic idle_drives();
        bus.req = '0; bus.bit_valid = '0; bus.bit_last = '0; bus.bit_in = '0;
    endtask

    // Each started source sends one packet; expected outputs come from the
    // packet timeline: grant, SYNC_LEN sync bits, payload, 2x SE0, J, gap.
    task automatic run_scen(input scen_t s, input int id);
        int cur, i, g, n, nv, p, e, last_start, nvk;
        int idx[3];
        logic [2:0] pending, took;
        logic [31:0] bits[3];
        bit u, first, done, act;
        int e_gnt, e_bstr, e_rdy, e_se0, e_abort, e_busy, e_take;
        bit skip_bstr;
        cur = -1; i = 0; e = 0; p = 0; pending = '0; took = '0;
        first = 1'b1; done = 1'b0; last_start = -1;
        for (int k = 0; k < 3; k++) begin
            idx[k] = 0;
            bits[k] = $urandom;
            if (s.start[k] > last_start) last_start = s.start[k];
        end
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (took[k]) idx[k]++;
                if (s.start[k] == cyc) pending[k] = 1'b1;
            end
            e_gnt = 0; e_bstr = 1; e_rdy = 0; e_se0 = 0; e_abort = 0; e_busy = 0;
            skip_bstr = 1'b0;
            if (cur >= 0) begin
                g  = cur;
                n  = s.len[g];
                u  = (s.under[g] < n);
                nv = u ? s.under[g] : n;
                p  = u ? SL + nv + 1 : SL + n;
                e  = p + 3 + IPG;
                e_gnt   = (i < p + 3) ? (1 << g) : 0;
                e_busy  = (i < e) ? 1 : 0;
                e_se0   = (i == p + 1 || i == p + 2) ? 1 : 0;
                e_abort = (u && i == p) ? 1 : 0;
                e_rdy   = (i >= 1 && i <= SL + nv) ? g + 1 : 0;
                if (i >= 1 && i <= SL)               e_bstr = (i == SL) ? 1 : 0;
                else if (i > SL && i <= SL + nv)     e_bstr = int'(bits[g][i-SL-1]);
                else if (u && i == p)                skip_bstr = 1'b1;
                else if (i == p + 1 || i == p + 2)   e_bstr = 0;
                if (first && i == 0 && s.first_gnt != 0)
                    chk($sformatf("s%0d first_gnt", id), int'(bus.gnt), int'(s.first_gnt));
                if (i == 0) first = 1'b0;
            end
            chk($sformatf("s%0d c%0d gnt", id, cyc), int'(bus.gnt), e_gnt);
            chk($sformatf("s%0d c%0d ready", id, cyc), int'(bus.bstr_out_ready), e_rdy);
            chk($sformatf("s%0d c%0d se0", id, cyc), int'(bus.se0), e_se0);
            chk($sformatf("s%0d c%0d abort", id, cyc), int'(bus.abort), e_abort);
            chk($sformatf("s%0d c%0d busy", id, cyc), int'(bus.busy), e_busy);
            if (!skip_bstr)
                chk($sformatf("s%0d c%0d bstr", id, cyc), int'(bus.bstr_out), e_bstr);
            for (int k = 0; k < 3; k++) begin
                act = pending[k] || (cur == k);
                nvk = (s.under[k] < s.len[k]) ? s.under[k] : s.len[k];
                bus.req[k]       = pending[k];
                bus.bit_valid[k] = act && (idx[k] < nvk);
                bus.bit_last[k]  = act && (idx[k] == s.len[k] - 1);
                bus.bit_in[k]    = bits[k][idx[k] % 32];
            end
            #1;
            e_take = (cur >= 0 && i >= SL && i < p) ? int'(bus.bit_valid & (3'b001 << cur)) : 0;
            chk($sformatf("s%0d c%0d take", id, cyc), int'(bus.bit_take), e_take);
            took = bus.bit_take;
            if (cur < 0 || i == e) begin
                if (pending != '0) begin
                    cur = pick(pending);
                    pending[cur] = 1'b0;
                    i = 0;
                end else begin
                    cur = -1;
                    if (cyc > last_start) done = 1'b1;
                end
            end else begin
                i++;
            end
        end
        if (!done) chk($sformatf("s%0d timeout", id), 0, 1);
        for (int k = 0; k < 3; k++) begin
            if (s.start[k] >= 0) begin
                nvk = (s.under[k] < s.len[k]) ? s.under[k] : s.len[k];
                chk($sformatf("s%0d src%0d bits taken", id, k), idx[k] + int'(took[k]), nvk);
            end
        end
        @(negedge clk);
        idle_drives();
    endtask

    scen_t tbl[6];
    scen_t rs;

    initial begin
        tbl[0] = mk( 0, -1, -1, 24, 1, 1, NONE, NONE, NONE, 3'b001);
        tbl[1] = mk( 0, -1,  0,  5, 1, 3, NONE, NONE, NONE, 3'b100);
        tbl[2] = mk(-1,  0, -1,  1, 10, 1, NONE, 5, NONE, 3'b010);
        tbl[3] = mk(-1,  0, 15,  1, 12, 4, NONE, NONE, NONE, 3'b010);
        tbl[4] = mk( 0,  0,  0,  4, 1, 2, 3, NONE, NONE, 3'b100);
        tbl[5] = mk(-1, -1,  2,  1, 1, 3, NONE, NONE, 0, 3'b100);

        idle_drives();
        bus0.req = '0; bus0.bit_valid = '0; bus0.bit_last = '0; bus0.bit_in = '0;

        #2 rst_b = 1'b0;
        #1;
        chk("rst gnt", int'(bus.gnt), 0);
        chk("rst bstr", int'(bus.bstr_out), 1);
        chk("rst ready", int'(bus.bstr_out_ready), 0);
        chk("rst se0", int'(bus.se0), 0);
        chk("rst abort", int'(bus.abort), 0);
        chk("rst busy", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;

        for (int t = 0; t < 6; t++) run_scen(tbl[t], t);

        // Reset in the middle of a data payload
        @(negedge clk);
        bus.req = 3'b010; bus.bit_valid = 3'b010; bus.bit_last = '0; bus.bit_in = '0;
        repeat (12) @(negedge clk);
        bus.req = '0;
        chk("mid xfer ready", int'(bus.bstr_out_ready), 2);
        #2 rst_b = 1'b0;
        #1;
        chk("async rst gnt", int'(bus.gnt), 0);
        chk("async rst bstr", int'(bus.bstr_out), 1);
        chk("async rst ready", int'(bus.bstr_out_ready), 0);
        chk("async rst se0", int'(bus.se0), 0);
        chk("async rst busy", int'(bus.busy), 0);
        @(negedge clk);
        idle_drives();
        rst_b = 1'b1;
        run_scen(tbl[0], 10);

        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < 3; k++) begin
                rs.start[k] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 30));
                rs.len[k]   = int'($urandom_range(1, 16));
                rs.under[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rs.len[k] - 1)) : NONE;
            end
            rs.first_gnt = '0;
            run_scen(rs, 20 + t);
        end

        // Zero-gap instance: a held token request is re-granted right after J
        @(negedge clk);
        bus0.req = 3'b001; bus0.bit_valid = 3'b001; bus0.bit_last = 3'b001; bus0.bit_in = '0;
        for (int c = 0; c < 5 && bus0.gnt == '0; c++) @(negedge clk);
        chk("ipg0 first gnt", int'(bus0.gnt), 1);
        repeat (12) @(negedge clk);
        chk("ipg0 J gnt", int'(bus0.gnt), 0);
        chk("ipg0 J busy", int'(bus0.busy), 0);
        chk("ipg0 J bstr", int'(bus0.bstr_out), 1);
        chk("ipg0 J se0", int'(bus0.se0), 0);
        @(negedge clk);
        chk("ipg0 regrant gnt", int'(bus0.gnt), 1);
        chk("ipg0 regrant busy", int'(bus0.busy), 1);
        bus0.req = '0;
        @(negedge clk);
        chk("ipg0 sync ready", int'(bus0.bstr_out_ready), 1);
        chk("ipg0 sync bit0", int'(bus0.bstr_out), 0);
        repeat (30) @(negedge clk);
        chk("ipg0 back idle", int'(bus0.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
